// File: rtl/gate_vector_sequencer.sv
// Drives a 2-input gate through all four a/b combinations, holds each for DWELL
// cycles, checks the gate output against the selected truth table and reports the result.
module gate_vector_sequencer #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] op,
    input  logic       c,
    output logic       a,
    output logic       b,
    output logic [1:0] vec_idx,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0]       OP_OR   = 2'b00;
    localparam logic [1:0]       OP_AND  = 2'b01;
    localparam logic [1:0]       OP_XOR  = 2'b10;
    localparam logic [CNT_W-1:0] DW_LAST = CNT_W'(DWELL - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [1:0]       op_q, op_d;
    logic [1:0]       vec_q, vec_d;
    logic [2:0]       err_q, err_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             expected;
    logic             mismatch;

    // Golden truth table for the operation captured at start, evaluated on the driven vector
    always_comb begin
        expected = 1'b0;
        case (op_q)
            OP_OR:   expected = vec_q[1] | vec_q[0];
            OP_AND:  expected = vec_q[1] & vec_q[0];
            OP_XOR:  expected = vec_q[1] ^ vec_q[0];
            default: expected = ~(vec_q[1] | vec_q[0]);
        endcase
    end

    assign mismatch = (c != expected);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dwell_q <= '0;
            op_q    <= '0;
            vec_q   <= '0;
            err_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            op_q    <= op_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        op_d    = op_q;
        vec_d   = vec_q;
        err_d   = err_q;
        done_d  = done_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    op_d    = op;
                    err_d   = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    vec_d   = '0;
                    dwell_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (dwell_q < DW_LAST) begin
                    dwell_d = dwell_q + 1'b1;
                end else begin
                    err_d = err_q + {2'b00, mismatch};
                    if (vec_q != 2'd3) begin
                        vec_d   = vec_q + 2'd1;
                        dwell_d = '0;
                    end else begin
                        // Last vector: its own compare result must count toward pass
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = (err_d == 3'd0);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign vec_idx = vec_q;
    assign a       = vec_q[1];
    assign b       = vec_q[0];
    assign busy    = (state_q == RUN);
    assign done    = done_q;
    assign pass    = pass_q;
    assign err_cnt = err_q;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Directed bench: two sequencers (DWELL=4 and DWELL=2) each driving a modelled gate
// that is either a correct OR or stuck at 0.
module tb_gate_vector_sequencer;

    localparam int D  = 4;
    localparam int D2 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, start2, bad, bad2;
    logic [1:0] op, op2;
    logic       a, b, busy, done, pass;
    logic       a2, b2, busy2, done2, pass2;
    logic [1:0] vec_idx, vec_idx2;
    logic [2:0] err_cnt, err_cnt2;
    logic       c, c2;

    assign c  = bad  ? 1'b0 : (a  | b);
    assign c2 = bad2 ? 1'b0 : (a2 | b2);

    int checks = 0;
    int errors = 0;

    gate_vector_sequencer #(.DWELL(D), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .c(c),
        .a(a), .b(b), .vec_idx(vec_idx), .busy(busy), .done(done),
        .pass(pass), .err_cnt(err_cnt)
    );

    gate_vector_sequencer #(.DWELL(D2), .CNT_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .op(op2), .c(c2),
        .a(a2), .b(b2), .vec_idx(vec_idx2), .busy(busy2), .done(done2),
        .pass(pass2), .err_cnt(err_cnt2)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge
    task automatic step();
        @(negedge clk);
    endtask

    // Full sweep on the DWELL=4 instance with per-cycle vector/timing checks.
    // Status word: {busy, done, pass, err_cnt[2:0], vec_idx[1:0]}
    task automatic sweep(input string tag, input logic [1:0] o, input logic bv,
                         input logic [2:0] exp_err);
        op = o; bad = bv; start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_start"}, {busy, done, err_cnt, vec_idx}, {1'b1, 1'b0, 3'd0, 2'd0});
        for (int j = 1; j < 4*D; j++) begin
            step();
            chk({tag, "_run"}, {busy, done, vec_idx, a, b},
                {1'b1, 1'b0, 2'(j / D), 1'(j / D / 2), 1'(j / D % 2)});
        end
        step();
        chk({tag, "_end"}, {busy, done, pass, err_cnt, vec_idx},
            {1'b0, 1'b1, (exp_err == 3'd0), exp_err, 2'd3});
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
        op = 2'b00; op2 = 2'b00; bad = 1'b0; bad2 = 1'b0;
        step(); step();
        chk("reset", {busy, done, pass, err_cnt, vec_idx, a, b}, 8'd0);
        chk("reset2", {busy2, done2, pass2, err_cnt2, vec_idx2, a2, b2}, 8'd0);
        rst_n = 1'b1;
        step();
        chk("idle_hold", {busy, done, vec_idx}, 4'd0);

        // Good OR against each expected op, then stuck-at-0 gate
        sweep("or_good", 2'b00, 1'b0, 3'd0);
        sweep("or_stuck0", 2'b00, 1'b1, 3'd3);
        sweep("and_stuck0", 2'b01, 1'b1, 3'd1);
        sweep("xor_vs_or", 2'b10, 1'b0, 3'd1);
        sweep("nor_vs_or", 2'b11, 1'b0, 3'd4);
        step();
        chk("done_hold", {busy, done, pass, err_cnt, vec_idx}, {1'b0, 1'b1, 1'b0, 3'd4, 2'd3});

        // Restart from DONE clears result on the accept edge (checked inside sweep)
        sweep("restart", 2'b00, 1'b0, 3'd0);

        // start with new op during the sweep is ignored
        op = 2'b00; bad = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (2*D) step();
        chk("ign_vec2", {busy, vec_idx}, {1'b1, 2'd2});
        op = 2'b01; start = 1'b1;
        step();
        start = 1'b0;
        chk("ign_after", {busy, done, vec_idx}, {1'b1, 1'b0, 2'd2});
        repeat (4*D - 2*D - 2) step();
        chk("ign_pre_end", {busy, done}, {1'b1, 1'b0});
        step();
        chk("ign_end", {busy, done, pass, err_cnt}, {1'b0, 1'b1, 1'b1, 3'd0});

        // Mid-sweep reset, with start asserted alongside (reset wins)
        op = 2'b11; start = 1'b1;
        step();
        start = 1'b0;
        repeat (2*D) step();
        chk("rst_vec2", {busy, vec_idx}, {1'b1, 2'd2});
        rst_n = 1'b0; start = 1'b1;
        step();
        rst_n = 1'b1; start = 1'b0;
        chk("mid_reset", {busy, done, pass, err_cnt, vec_idx, a, b}, 8'd0);
        step();
        chk("post_reset_idle", {busy, done}, 2'b00);
        sweep("after_reset", 2'b00, 1'b0, 3'd0);

        // DWELL=2 instance: sweep completes in 8 cycles
        op2 = 2'b00; bad2 = 1'b0; start2 = 1'b1;
        step();
        start2 = 1'b0;
        chk("d2_start", {busy2, vec_idx2}, {1'b1, 2'd0});
        step(); step();
        chk("d2_vec1", {busy2, vec_idx2, a2, b2}, {1'b1, 2'd1, 1'b0, 1'b1});
        repeat (5) step();
        chk("d2_pre_end", {busy2, done2, vec_idx2}, {1'b1, 1'b0, 2'd3});
        step();
        chk("d2_end", {busy2, done2, pass2, err_cnt2}, {1'b0, 1'b1, 1'b1, 3'd0});
        op2 = 2'b00; bad2 = 1'b1; start2 = 1'b1;
        step();
        start2 = 1'b0;
        repeat (7) step();
        chk("d2_bad_pre", {busy2, done2}, {1'b1, 1'b0});
        step();
        chk("d2_bad_end", {busy2, done2, pass2, err_cnt2}, {1'b0, 1'b1, 1'b0, 3'd3});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
